// File: rtl/btn_press_decoder.sv
// Turns a debounced button level into press / click / long-press / repeat / release events.
// Optional auto-repeat while held is enabled by defining BTN_AUTOREPEAT_EN.
module btn_press_decoder #(
    parameter int unsigned LONG_CYCLES   = 2000,
    parameter int unsigned REPEAT_CYCLES = 200,
    parameter int unsigned CNT_W         = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic press_pulse,
    output logic short_click,
    output logic long_press,
    output logic repeat_pulse,
    output logic release_pulse,
    output logic held
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 2);

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        IDLE     = 2'd1,
        PRESSED  = 2'd2,
        LONG     = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Elaboration-time guard against illegal thresholds
    if (LONG_CYCLES < 2) begin : g_bad_long
        $error("btn_press_decoder: LONG_CYCLES must be >= 2");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("btn_press_decoder: REPEAT_CYCLES must be >= 1");
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

    // Event FSM; release always wins over a threshold reached on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= WAIT_LOW;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            short_click   <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            release_pulse <= 1'b0;
            held          <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            short_click   <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                WAIT_LOW: begin
                    // A button held through reset is swallowed until it goes low
                    if (!btn_in) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (btn_in) begin
                        state       <= PRESSED;
                        cnt         <= '0;
                        press_pulse <= 1'b1;
                        held        <= 1'b1;
                    end
                end
                PRESSED: begin
                    if (!btn_in) begin
                        state         <= IDLE;
                        short_click   <= 1'b1;
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                    end else if (cnt == LONG_LAST) begin
                        state      <= LONG;
                        cnt        <= '0;
                        long_press <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                LONG: begin
                    if (!btn_in) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                    end else if (cnt == REPEAT_LAST) begin
                        cnt          <= '0;
                        repeat_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
`else
                    end else begin
                        cnt <= '0;
                    end
`endif
                end
                default: begin
                    state <= WAIT_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_press_decoder.sv
// Scoreboard bench for btn_press_decoder with LONG_CYCLES=8, REPEAT_CYCLES=3.
// Expected repeat behaviour follows BTN_AUTOREPEAT_EN.
module tb_btn_press_decoder;

    localparam int unsigned LONG_CYCLES   = 8;
    localparam int unsigned REPEAT_CYCLES = 3;
    localparam int unsigned CNT_W         = 4;

    logic clk;
    logic rst_n;
    logic btn_in;
    logic press_pulse, short_click, long_press, repeat_pulse, release_pulse, held;

    int errors = 0;
    int checks = 0;

    // {press, short, long, repeat, release, held}
    logic [5:0] exp_q[$];

    btn_press_decoder #(
        .LONG_CYCLES  (LONG_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_in       (btn_in),
        .press_pulse  (press_pulse),
        .short_click  (short_click),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse),
        .release_pulse(release_pulse),
        .held         (held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [5:0] outs();
        return {press_pulse, short_click, long_press, repeat_pulse, release_pulse, held};
    endfunction

    // Expected outputs after edge P+k for a press sampled high on l consecutive edges
    function automatic logic [5:0] exp_at(input int k, input int l);
        logic [5:0] e;
        e = 6'b0;
        if (k == 0) e = 6'b100001;
        else if (k < l) begin
            e[0] = 1'b1;
            if (k == int'(LONG_CYCLES) - 1) e[3] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
            if (k > int'(LONG_CYCLES) - 1 && ((k - (int'(LONG_CYCLES) - 1)) % int'(REPEAT_CYCLES)) == 0)
                e[2] = 1'b1;
`endif
        end else if (k == l) begin
            e[1] = 1'b1;
            if (l < int'(LONG_CYCLES)) e[4] = 1'b1;
        end
        return e;
    endfunction

    // Drive one sample; the expected value queued now is checked after the edge
    task automatic cycle(input logic b, input logic [5:0] e, input string name);
        logic [5:0] want;
        btn_in = b;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        want = exp_q.pop_front();
        checks++;
        if (outs() !== want) begin
            errors++;
            $display("FAIL %s: got {press,short,long,rep,rel,held}=%b expected %b at %0t",
                     name, outs(), want, $time);
        end
    endtask

    task automatic run_press(input int l, input string name);
        for (int k = 0; k <= l; k++) cycle(k < l, exp_at(k, l), name);
    endtask

    task automatic idle_cycles(input int n, input logic b, input string name);
        for (int i = 0; i < n; i++) cycle(b, 6'b0, name);
    endtask

    task automatic test_reset();
        btn_in = 1'b1;
        rst_n  = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs() !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000", outs());
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(20, 1'b1, "reset_hold_silent");
        idle_cycles(2, 1'b0, "reset_low_silent");
        run_press(4, "reset_then_press4");
        idle_cycles(2, 1'b0, "reset_after_idle");
    endtask

    task automatic test_short();
        run_press(7, "short_7_edges");
        idle_cycles(2, 1'b0, "short_idle");
        run_press(1, "min_press");
        idle_cycles(1, 1'b0, "min_idle");
    endtask

    task automatic test_long();
        run_press(8, "long_8_edges");
        idle_cycles(2, 1'b0, "long_idle");
        run_press(20, "long_20_edges");
        idle_cycles(2, 1'b0, "long20_idle");
    endtask

    task automatic test_release_on_repeat();
        run_press(10, "release_on_repeat_edge");
        idle_cycles(1, 1'b0, "rel_rep_idle");
    endtask

    task automatic test_back_to_back();
        run_press(2, "b2b_first");
        run_press(3, "b2b_second");
        idle_cycles(1, 1'b0, "b2b_idle");
    endtask

    task automatic test_reset_mid_press();
        for (int k = 0; k <= 5; k++) cycle(1'b1, exp_at(k, 100), "midreset_before");
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs() !== 6'b0) begin
            errors++;
            $display("FAIL midreset_async: got %b expected 000000", outs());
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(12, 1'b1, "midreset_hold_silent");
        idle_cycles(1, 1'b0, "midreset_low");
        run_press(3, "midreset_new_press");
        idle_cycles(1, 1'b0, "midreset_idle");
    endtask

    initial begin
        rst_n  = 1'b0;
        btn_in = 1'b0;
        test_reset();
        test_short();
        test_long();
        test_release_on_repeat();
        test_back_to_back();
        test_reset_mid_press();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/btn_press_decoder.md
# btn_press_decoder

Consumes the clean, single-clock-domain button level produced by the debouncer and converts it into discrete user-intent events for the clock/alarm control logic. Events are press, short click, long press, release and optional auto-repeat while held. The mode/set FSM uses these events to increment hours/minutes and toggle the alarm. All outputs are registered single-cycle pulses except `held`.

## Interface
- `LONG_CYCLES`, 2000: edges of `btn_in` held high, counted from the press edge, before `long_press` fires. Legal range is ≥2.
- `REPEAT_CYCLES`, 200: auto-repeat period in clock edges, counted from `long_press`. Legal range is ≥1.
- `CNT_W`, 12: counter width. It must hold max(`LONG_CYCLES`, `REPEAT_CYCLES`) − 1.
- `clk` input 1: sampling clock, same clock as the debouncer (1–10 kHz).
- `rst_n` input 1: asynchronous, active-low reset.
- `btn_in` input 1: clean button level, already synchronous to `clk`.
- `press_pulse` output 1: one-cycle pulse on accepted press.
- `short_click` output 1: one-cycle pulse on release before the long threshold.
- `long_press` output 1: one-cycle pulse when the long threshold is reached.
- `repeat_pulse` output 1: one-cycle pulse every `REPEAT_CYCLES` while in the long hold.
- `release_pulse` output 1: one-cycle pulse on every release of an accepted press.
- `held` output 1: level, high from press acceptance until release.

## Operation
- States: `WAIT_LOW`, `IDLE`, `PRESSED`, `LONG`. One counter `cnt` (`CNT_W` bits).
- `WAIT_LOW` (reset state):
  - `btn_in`=0 → `IDLE`.
  - Otherwise stay. A button held through reset is never reported.
- `IDLE`:
  - `btn_in`=1 → `PRESSED`, `cnt`←0, `press_pulse`=1, `held`=1.
- `PRESSED`:
  - `btn_in`=0 → `IDLE`, `short_click`=1, `release_pulse`=1, `held`=0.
  - Else if `cnt`==`LONG_CYCLES`−2 → `LONG`, `cnt`←0, `long_press`=1.
  - Else `cnt`←`cnt`+1.
- `LONG`:
  - `btn_in`=0 → `IDLE`, `release_pulse`=1, `held`=0. No `short_click`.
  - Else if `cnt`==`REPEAT_CYCLES`−1 → `cnt`←0, `repeat_pulse`=1.
  - Else `cnt`←`cnt`+1.
- Release has priority over a threshold or repeat reached on the same edge. That edge produces only the release events.
- Counter never wraps: it is cleared at every threshold. A hold of unlimited duration repeats indefinitely.
- `press_pulse` and `long_press`/`repeat_pulse`/`short_click` are mutually exclusive in any cycle.

## Timing
- Reset: all pulse outputs 0, `held`=0, state `WAIT_LOW`, `cnt`=0. This takes effect immediately on `rst_n` low, independent of `clk`.
- Reset mid-press: events are dropped. A new press is reported only after `btn_in` is sampled 0 at least once.
- `press_pulse`: visible in the cycle after the first edge that samples `btn_in`=1 in `IDLE`. Latency is 1 edge.
- `long_press`: asserted after edge P+`LONG_CYCLES`−1, where P is the press edge. It requires `btn_in`=1 at every edge in between.
- First `repeat_pulse`: `REPEAT_CYCLES` edges after `long_press`, then every `REPEAT_CYCLES` edges.
- Release events: visible in the cycle after the first edge that samples `btn_in`=0.
- Minimum press is one sample high, which is still reported as press plus click.
- Back-to-back press is legal: release at edge R, press at edge R+1 is accepted.

## Configuration
- `BTN_AUTOREPEAT_EN` defined:
  - `repeat_pulse` behaves as specified.
  - `cnt` is reused in `LONG`.
- `BTN_AUTOREPEAT_EN` not defined:
  - `repeat_pulse` is tied to 0.
  - In `LONG`, `cnt` holds at 0 and only a release exits the state.
  - All other behaviour is identical.

## Test plan
All scenarios use `LONG_CYCLES`=8 and `REPEAT_CYCLES`=3.
- Reset with `btn_in`=1 held 20 cycles, then low 2, then high 4, then low:
  - No events during the first hold.
  - Then one `press_pulse`, then one `short_click`+`release_pulse`.
  - `held` is high for 4 cycles.
- Press held exactly 7 edges, then release:
  - `short_click`, no `long_press`.
- Press held 8 edges:
  - `long_press` after edge P+7.
- Press held 20 edges, macro defined:
  - `long_press` at P+7, `repeat_pulse` at P+10, P+13, P+16, P+19.
  - Then `release_pulse`, no `short_click`.
- Release on the edge where the repeat would fire (P+10 sampled 0):
  - Only `release_pulse`, no `repeat_pulse`.
- `rst_n` pulsed low at P+5 while still held:
  - All outputs 0 immediately.
  - No further events until `btn_in` low then high again.
- Macro undefined, 20-edge hold:
  - `repeat_pulse` never asserts.
  - `long_press` and release timing are identical to the macro-defined case.
